// File: rtl/dmem_copier.sv
// Block copy / block fill engine that drives the data-memory port.
// Memory-side outputs are decoded from registered state and pointers only.
module dmem_copier #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                     clock,
    input  logic                     n_reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [WORD_W-OP_W-1:0]   src,
    input  logic [WORD_W-OP_W-1:0]   dst,
    input  logic [WORD_W-OP_W:0]     len,
    input  logic [WORD_W-1:0]        fill_data,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [WORD_W-OP_W:0]     count,
    output logic [WORD_W-OP_W-1:0]   Daddress,
    output logic [WORD_W-1:0]        Wdata,
    output logic                     WE,
    input  logic [WORD_W-1:0]        Mdata
);

    localparam int A_W = WORD_W - OP_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [A_W-1:0] PTR_ONE = {{(A_W-1){1'b0}}, 1'b1};
    localparam logic [A_W:0]   CNT_ONE = {{A_W{1'b0}}, 1'b1};
    localparam logic [A_W:0]   CNT_ZERO = {(A_W+1){1'b0}};

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic              mode_r;
    logic [A_W-1:0]    src_ptr_r;
    logic [A_W-1:0]    dst_ptr_r;
    logic [A_W:0]      remaining_r;
    logic [A_W:0]      count_r;
    logic [WORD_W-1:0] fill_r;
    logic [WORD_W-1:0] data_r;

    // Next-state selection; abort only acts outside IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else if (mode) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (remaining_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else if (mode_r) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, command capture, pointers and word counters.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            src_ptr_r   <= {A_W{1'b0}};
            dst_ptr_r   <= {A_W{1'b0}};
            remaining_r <= CNT_ZERO;
            count_r     <= CNT_ZERO;
            fill_r      <= {WORD_W{1'b0}};
            data_r      <= {WORD_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r      <= mode;
                        src_ptr_r   <= src;
                        dst_ptr_r   <= dst;
                        remaining_r <= len;
                        fill_r      <= fill_data;
                        count_r     <= CNT_ZERO;
                    end
                end
                ST_READ: begin
                    data_r    <= Mdata;
                    src_ptr_r <= src_ptr_r + PTR_ONE;
                end
                ST_WRITE: begin
                    // The write presented this cycle lands even when aborted.
                    dst_ptr_r   <= dst_ptr_r + PTR_ONE;
                    count_r     <= count_r + CNT_ONE;
                    remaining_r <= remaining_r - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory port and status decode from registered state.
    always_comb begin
        Daddress = {A_W{1'b0}};
        Wdata    = {WORD_W{1'b0}};
        WE       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            ST_READ: begin
                Daddress = src_ptr_r;
                busy     = 1'b1;
            end
            ST_WRITE: begin
                Daddress = dst_ptr_r;
                WE       = 1'b1;
                busy     = 1'b1;
                if (mode_r) begin
                    Wdata = fill_r;
                end else begin
                    Wdata = data_r;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign count = count_r;

endmodule

// File: tb/tb_dmem_copier.sv
// Directed self-checking bench for dmem_copier with a 32-word memory model.
module tb_dmem_copier;

    logic       clock;
    logic       n_reset;
    logic       start;
    logic       mode;
    logic [4:0] src;
    logic [4:0] dst;
    logic [5:0] len;
    logic [7:0] fill_data;
    logic       abort;
    logic       busy;
    logic       done;
    logic [5:0] count;
    logic [4:0] Daddress;
    logic [7:0] Wdata;
    logic       WE;
    logic [7:0] Mdata;

    logic [7:0] mem [32];
    logic       pre_we;
    logic [4:0] pre_addr;
    logic [7:0] pre_data;

    int checks;
    int errors;
    int dcyc;
    logic [63:0] wmask;

    dmem_copier #(.WORD_W(8), .OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_data(fill_data), .abort(abort),
        .busy(busy), .done(done), .count(count), .Daddress(Daddress),
        .Wdata(Wdata), .WE(WE), .Mdata(Mdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign Mdata = mem[Daddress];

    // Memory model: DUT writes, plus bench preload while the DUT is idle.
    always @(posedge clock) begin
        if (WE) mem[Daddress] <= Wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we = 1'b1;
        @(posedge clock); #1;
        pre_we = 1'b0;
    endtask

    // Issue one command; report done cycle (-1 if none) and cycles with WE high.
    task automatic run_op(input logic m, input logic [4:0] s, input logic [4:0] d,
                          input logic [5:0] l, input logic [7:0] f,
                          input int ab, input int rs,
                          output int dc, output logic [63:0] mask);
        bit fin;
        mode = m; src = s; dst = d; len = l; fill_data = f; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        dc = -1;
        mask = 64'd0;
        fin = 1'b0;
        for (int k = 1; k <= 100 && !fin; k++) begin
            if (WE && k < 64) mask[k] = 1'b1;
            if (done) begin
                dc = k;
                fin = 1'b1;
            end
            if (k == ab) fin = 1'b1;
            abort = (k == ab);
            start = (k == rs);
            if (k == rs) begin
                mode = 1'b0; src = 5'd0; dst = 5'd16; len = 6'd2; fill_data = 8'h00;
            end
            @(posedge clock); #1;
            abort = 1'b0;
            start = 1'b0;
        end
        if (!fin) chk("op_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        checks = 0; errors = 0;
        n_reset = 1'b0; start = 1'b0; mode = 1'b0; src = 5'd0; dst = 5'd0;
        len = 6'd0; fill_data = 8'h00; abort = 1'b0;
        pre_we = 1'b0; pre_addr = 5'd0; pre_data = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_count", {58'd0, count}, 64'd0);
        chk("rst_we", {63'd0, WE}, 64'd0);
        chk("rst_addr", {59'd0, Daddress}, 64'd0);
        chk("rst_wdata", {56'd0, Wdata}, 64'd0);
        n_reset = 1'b1;
        for (int i = 0; i < 32; i++) poke(i[4:0], 8'h00);

        // Copy of four words
        poke(5'd4, 8'hA1); poke(5'd5, 8'hB2); poke(5'd6, 8'hC3); poke(5'd7, 8'hD4);
        run_op(1'b0, 5'd4, 5'd20, 6'd4, 8'h00, 0, 0, dcyc, wmask);
        chk("copy_done_cyc", 64'(dcyc), 64'd9);
        chk("copy_we_mask", wmask, 64'h154);
        chk("copy_m20", {56'd0, mem[20]}, 64'hA1);
        chk("copy_m21", {56'd0, mem[21]}, 64'hB2);
        chk("copy_m22", {56'd0, mem[22]}, 64'hC3);
        chk("copy_m23", {56'd0, mem[23]}, 64'hD4);
        chk("copy_count", {58'd0, count}, 64'd4);
        chk("copy_busy", {63'd0, busy}, 64'd0);

        // Fill wrapping past the top of memory
        poke(5'd1, 8'h77);
        run_op(1'b1, 5'd0, 5'd30, 6'd3, 8'h5A, 0, 0, dcyc, wmask);
        chk("fill_done_cyc", 64'(dcyc), 64'd4);
        chk("fill_we_mask", wmask, 64'hE);
        chk("fill_m30", {56'd0, mem[30]}, 64'h5A);
        chk("fill_m31", {56'd0, mem[31]}, 64'h5A);
        chk("fill_m0", {56'd0, mem[0]}, 64'h5A);
        chk("fill_m1", {56'd0, mem[1]}, 64'h77);
        chk("fill_count", {58'd0, count}, 64'd3);

        // Overlapping forward copy replicates the first word
        poke(5'd10, 8'h11); poke(5'd11, 8'h00); poke(5'd12, 8'h00);
        poke(5'd13, 8'h00); poke(5'd14, 8'h99);
        run_op(1'b0, 5'd10, 5'd11, 6'd3, 8'h00, 0, 0, dcyc, wmask);
        chk("ovl_done_cyc", 64'(dcyc), 64'd7);
        chk("ovl_m11", {56'd0, mem[11]}, 64'h11);
        chk("ovl_m12", {56'd0, mem[12]}, 64'h11);
        chk("ovl_m13", {56'd0, mem[13]}, 64'h11);
        chk("ovl_m14", {56'd0, mem[14]}, 64'h99);

        // Zero-length command
        run_op(1'b0, 5'd4, 5'd20, 6'd0, 8'h00, 0, 0, dcyc, wmask);
        chk("len0_done_cyc", 64'(dcyc), 64'd1);
        chk("len0_we_mask", wmask, 64'd0);
        chk("len0_count", {58'd0, count}, 64'd0);

        // Second start during a fill is ignored
        poke(5'd16, 8'h42);
        run_op(1'b1, 5'd0, 5'd8, 6'd8, 8'h3C, 0, 3, dcyc, wmask);
        chk("bstart_done_cyc", 64'(dcyc), 64'd9);
        chk("bstart_we_mask", wmask, 64'h1FE);
        chk("bstart_m8", {56'd0, mem[8]}, 64'h3C);
        chk("bstart_m15", {56'd0, mem[15]}, 64'h3C);
        chk("bstart_m16", {56'd0, mem[16]}, 64'h42);
        chk("bstart_count", {58'd0, count}, 64'd8);

        // Abort during fill
        for (int i = 0; i < 8; i++) poke(i[4:0], 8'h60 + 8'(i));
        run_op(1'b1, 5'd0, 5'd0, 6'd8, 8'hFF, 3, 0, dcyc, wmask);
        chk("abort_no_done", 64'(dcyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_we_mask", wmask, 64'hE);
        chk("abort_m0", {56'd0, mem[0]}, 64'hFF);
        chk("abort_m2", {56'd0, mem[2]}, 64'hFF);
        chk("abort_m3", {56'd0, mem[3]}, 64'h63);
        chk("abort_m7", {56'd0, mem[7]}, 64'h67);
        chk("abort_count", {58'd0, count}, 64'd3);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        @(posedge clock); #1;
        chk("abort_no_late_done", {63'd0, done}, 64'd0);

        // Asynchronous reset in the middle of a copy write
        mode = 1'b0; src = 5'd4; dst = 5'd24; len = 6'd4; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("mid_we_high", {63'd0, WE}, 64'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_rst_we", {63'd0, WE}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_addr", {59'd0, Daddress}, 64'd0);
        @(posedge clock); #1;
        chk("mid_rst_m24", {56'd0, mem[24]}, 64'h00);
        n_reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_copier.md
Name: dmem_copier

Overview:
- Bus-initiator engine that drives the data-memory port (Daddress, Wdata, WE) and consumes its asynchronous read data (Mdata).
- Performs block copy (memory to memory) or block fill (constant to memory) of up to 2**(WORD_W-OP_W) words.
- Sits beside the processor datapath. While busy it owns the data-memory port; arbitration is external.

Parameters:
- WORD_W, 8, data word width in bits.
- OP_W, 3, opcode width; memory address width A_W = WORD_W-OP_W (default 5, 32 words).

Ports:
- clock  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; captured on accepted start.
- src  input  A_W  copy source base address; captured on start.
- dst  input  A_W  destination base address; captured on start.
- len  input  A_W+1  word count, 0 to 2**A_W; captured on start.
- fill_data  input  WORD_W  fill value; captured on start.
- abort  input  1  terminates an operation in progress.
- busy  output  1  high from the cycle after an accepted start until DONE or abort.
- done  output  1  one-cycle completion pulse.
- count  output  A_W+1  words written so far in the current or last operation.
- Daddress  output  A_W  memory address.
- Wdata  output  WORD_W  memory write data.
- WE  output  1  memory write enable.
- Mdata  input  WORD_W  memory read data, combinational from Daddress.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - State goes to IDLE immediately on n_reset low.
  - busy=0, done=0, count=0, WE=0, Daddress=0, Wdata=0.
  - All captured registers and pointers clear to 0.
  - Reset mid-operation drops WE at once. A partial copy is left as is.
- Memory-side outputs (Daddress, Wdata, WE) are decoded from registered state and pointers only. There is no combinational path from any input to them.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: Daddress=0, WE=0, Wdata=0.
  - On start=1: capture mode, src, dst, len, fill_data; set count=0.
  - len=0 -> DONE.
  - Otherwise copy -> READ, fill -> WRITE.
- READ (copy only): Daddress=src_ptr, WE=0. At the clock edge, Mdata is registered into data_reg, src_ptr increments, and the FSM moves to WRITE.
- WRITE: Daddress=dst_ptr, WE=1. Wdata=data_reg for copy, fill value for fill. At the edge:
  - dst_ptr increments; count increments; remaining decrements.
  - If remaining was 1 -> DONE.
  - Else copy -> READ, fill stays in WRITE.
- DONE: done=1 for exactly one cycle, busy=0, WE=0, then IDLE. A start in the DONE cycle is ignored.
- Latency, counting the start-sampling edge as cycle 0:
  - Copy of N words: writes in cycles 2, 4, ..., 2N; done in cycle 2N+1.
  - Fill of N words: writes in cycles 1..N; done in cycle N+1.
  - len=0: done in cycle 1, no memory access.
- Pointers are A_W bits and wrap modulo 2**A_W. Example: src=30, len=4 reads 30, 31, 0, 1.
- Overlap: copy is strictly forward, word by word, with each read completing before the following write.
  - dst=src+1 therefore replicates the first word across the region. This is the defined behaviour.
- start while busy is ignored.
- abort=1 in READ, WRITE or DONE -> IDLE at the next edge.
  - The write presented in that cycle still occurs.
  - done is not pulsed; count holds its value.
  - abort has priority over the DONE transition only in the sense that done is suppressed.
- abort in IDLE has no effect. start and abort together in IDLE: start wins.
- count holds its value after completion until the next accepted start.

Test Plan:
- Reset: drive n_reset low mid-copy (WE=1) -> WE, busy and done go to 0 without a clock edge; Daddress=0.
- Copy: preload mem[4..7]=8'hA1,B2,C3,D4; start with mode=0, src=4, dst=20, len=4 -> mem[20..23] matches; done in cycle 9; count=4; WE high only in even cycles 2..8.
- Fill with wrap: mode=1, dst=30, fill_data=8'h5A, len=3 -> mem[30], mem[31], mem[0] = 8'h5A; mem[1] unchanged; done in cycle 4.
- Overlap: mem[10]=8'h11, mem[11..13]=0; copy src=10, dst=11, len=3 -> mem[11..13]=8'h11.
- len=0 and busy-start: len=0 -> done in cycle 1, WE never high; a second start during a len=8 fill is ignored and the fill completes unchanged.
- Abort: fill dst=0, len=8, fill_data=8'hFF, abort in cycle 3 -> mem[0..2]=8'hFF, mem[3..7] unchanged, no done pulse, count=3, busy=0.
